// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module   : reg_file_pkg
// Brief    : Shared types and default widths for the parametrised register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

endpackage

`default_nettype wire

// File: rtl/reg_file_clear_fsm.sv
// ============================================================================
// Module   : reg_file_clear_fsm
// Brief    : Clear-sweep sequencer; walks every entry once after reset or on request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear_req,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_idx
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = '1;

    rf_state_e         r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                RF_IDLE: begin
                    if (i_clear_req) begin
                        r_state   <= RF_CLEAR;
                        r_clr_idx <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    // Index wraps back to 0 naturally after the last entry.
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == c_LAST_IDX) begin
                        r_state <= RF_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RF_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_clr_we  = r_busy & ~i_rst;
    assign o_clr_idx = r_clr_idx;

endmodule

`default_nettype wire

// File: rtl/param_reg_file.sv
// ============================================================================
// Module   : param_reg_file
// Brief    : 1W / NUM_RD-R register file with optional zero register and clear sweep.
//            Define PARAM_REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module param_reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     writeEnable,
    input  logic [ADDR_W-1:0]        writeAddress,
    input  logic [DATA_W-1:0]        writeData,
    input  logic [NUM_RD*ADDR_W-1:0] readAddress,
    output logic [NUM_RD*DATA_W-1:0] readData,
    input  logic                     clearReq,
    output logic                     busy,
    output logic                     writeDropped
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic              r_write_dropped;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_zero_tgt;
    logic              w_user_we;
    logic              w_drop;

    reg_file_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_clear_req (clearReq),
        .o_busy      (w_busy),
        .o_clr_we    (w_clr_we),
        .o_clr_idx   (w_clr_idx)
    );

    // Zero-register writes vanish silently; they never count as dropped.
    assign w_zero_tgt = (ZERO_REG != 0) && (writeAddress == '0);
    assign w_user_we  = writeEnable && !w_busy && !clearReq && !RST && !w_zero_tgt;
    assign w_drop     = writeEnable && (w_busy || clearReq) && !w_zero_tgt;

    always_ff @(posedge CLK) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_user_we) begin
            r_mem[writeAddress] <= writeData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_write_dropped <= 1'b0;
        end else begin
            r_write_dropped <= w_drop;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_stored;
            logic [DATA_W-1:0] w_val;

            assign w_addr   = readAddress[k*ADDR_W +: ADDR_W];
            assign w_stored = ((ZERO_REG != 0) && (w_addr == '0)) ? '0 : r_mem[w_addr];
`ifdef PARAM_REG_FILE_BYPASS_EN
            assign w_val    = (w_user_we && (w_addr == writeAddress)) ? writeData : w_stored;
`else
            assign w_val    = w_stored;
`endif
            assign readData[k*DATA_W +: DATA_W] = w_busy ? '0 : w_val;
        end
    endgenerate

    assign busy         = w_busy;
    assign writeDropped = r_write_dropped;

endmodule

`default_nettype wire

// File: tb/tb_param_reg_file.sv
// ============================================================================
// Module   : tb_param_reg_file
// Brief    : Directed plus random bench; ZERO_REG=1 and ZERO_REG=0 instances share stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_param_reg_file;

    logic        CLK = 1'b0;
    logic        RST;
    logic        writeEnable;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic [9:0]  readAddress;
    logic        clearReq;

    logic [63:0] rd_z, rd_n;
    logic        busy_z, busy_n, drop_z, drop_n;

    int n_cmp = 0;
    int n_err = 0;

    // Model: sweep is abstracted as "whole array zero, busy for rem more edges".
    logic [31:0] mdl [2][32];
    int          rem = 32;
    logic        mdrop [2];

    always #5 CLK = ~CLK;

    param_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut_z (
        .CLK(CLK), .RST(RST), .writeEnable(writeEnable), .writeAddress(writeAddress),
        .writeData(writeData), .readAddress(readAddress), .readData(rd_z),
        .clearReq(clearReq), .busy(busy_z), .writeDropped(drop_z)
    );

    param_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) u_dut_n (
        .CLK(CLK), .RST(RST), .writeEnable(writeEnable), .writeAddress(writeAddress),
        .writeData(writeData), .readAddress(readAddress), .readData(rd_n),
        .clearReq(clearReq), .busy(busy_n), .writeDropped(drop_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int inst, input logic [4:0] a);
        if (rem > 0) return 32'h0;
        if (inst == 0 && a == 5'd0) return 32'h0;
`ifdef PARAM_REG_FILE_BYPASS_EN
        if (writeEnable && !clearReq && !RST && writeAddress == a) return writeData;
`endif
        return mdl[inst][a];
    endfunction

    task automatic model_edge(input logic r, input logic w, input logic [4:0] wa,
                              input logic [31:0] wd, input logic c);
        if (r || (rem == 0 && c)) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 32; j++) mdl[i][j] = 32'h0;
                mdrop[i] = r ? 1'b0 : (w && !(i == 0 && wa == 5'd0));
            end
            rem = 32;
        end else if (rem > 0) begin
            for (int i = 0; i < 2; i++) mdrop[i] = w && !(i == 0 && wa == 5'd0);
            rem--;
        end else begin
            for (int i = 0; i < 2; i++) begin
                mdrop[i] = 1'b0;
                if (w && !(i == 0 && wa == 5'd0)) mdl[i][wa] = wd;
            end
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a0, input logic [4:0] a1, input logic c, input bit do_chk);
        RST          = r;
        writeEnable  = w;
        writeAddress = wa;
        writeData    = wd;
        readAddress  = {a1, a0};
        clearReq     = c;
        #1;
        if (do_chk) begin
            chk("busy_z", {31'b0, busy_z}, {31'b0, rem > 0});
            chk("busy_n", {31'b0, busy_n}, {31'b0, rem > 0});
            chk("drop_z", {31'b0, drop_z}, {31'b0, mdrop[0]});
            chk("drop_n", {31'b0, drop_n}, {31'b0, mdrop[1]});
            chk("rd0_z", rd_z[31:0],  exp_rd(0, a0));
            chk("rd1_z", rd_z[63:32], exp_rd(0, a1));
            chk("rd0_n", rd_n[31:0],  exp_rd(1, a0));
            chk("rd1_n", rd_n[63:32], exp_rd(1, a1));
        end
        @(posedge CLK);
        model_edge(r, w, wa, wd, c);
        @(negedge CLK);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 5'($urandom), 32'($urandom), 5'($urandom), 5'($urandom), 1'b0, 1'b1);
    endtask

    task automatic count_busy(input string tag);
        int cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_z === 1'b1) cnt++;
            idle_step();
        end
        chk(tag, 32'(cnt), 32'd32);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_z === 1'b1 && n < 40) begin
            idle_step();
            n++;
        end
        chk("idle_timeout", {31'b0, busy_z}, 32'h0);
    endtask

    initial begin
        mdrop[0] = 1'b0;
        mdrop[1] = 1'b0;

        // Reset held for three cycles, then the full-depth sweep.
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd9, 32'h99, 5'd2, 5'd3, 1'b0, 1'b1);
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b0, 1'b1);
        count_busy("reset_sweep_len");
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(2*i), 5'(2*i+1), 1'b0, 1'b1);

        // Basic write then read back.
        step(1'b0, 1'b1, 5'd4, 32'h0001_0000, 5'd4, 5'd5, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b0, 1'b1);

        // Zero register behaviour differs between the two instances.
        step(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd4, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 1'b0, 1'b1);

        // Write two cycles into a requested clear is dropped.
        step(1'b0, 1'b1, 5'd7, 32'h5555_5555, 5'd7, 5'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 1'b1);
        idle_step();
        step(1'b0, 1'b1, 5'd7, 32'h0000_1234, 5'd7, 5'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 1'b1);
        wait_idle();
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd4, 1'b0, 1'b1);

        // Reset at sweep cycle 10 restarts the full sweep.
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) idle_step();
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);
        count_busy("midsweep_reset_len");

        // Same-cycle read of the write target.
        step(1'b0, 1'b1, 5'd3, 32'h1111_0000, 5'd3, 5'd3, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 1'b1);

        // Write and clear request together: clear wins, write dropped.
        step(1'b0, 1'b1, 5'd6, 32'h6666_6666, 5'd6, 5'd3, 1'b1, 1'b1);
        idle_step();
        wait_idle();

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0), 1'($urandom), 5'($urandom), 32'($urandom),
                 5'($urandom), 5'($urandom), ($urandom_range(0, 59) == 0), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
